updown_sched: RTL and testbench
===============================

UPDOWN_SCHED -- requirements
Module: updown_sched

Interface
REQ-001 Parameter LEN_W, default 8: width of each requester's step-count field.
REQ-002 Parameter NREQ is fixed at 2 requesters (index 0 and 1) and is not a parameter.
REQ-003 clock  input  1  single clock; all state updates on posedge clock.
REQ-004 reset  input  1  asynchronous, active-low reset; asserting low clears all state immediately; deassertion is sampled on posedge clock.
REQ-005 req  input  2  per-requester request level; held high until the matching done pulse.
REQ-006 dir  input  2  per-requester direction: 0 = count up, 1 = count down (same encoding as the counter inst input).
REQ-007 len0, len1  input  LEN_W  step count for requester 0 / 1; sampled only at grant.
REQ-008 gnt  output  2  one-hot grant; high from grant through the done cycle.
REQ-009 done  output  2  one-cycle pulse to the served requester on normal completion.
REQ-010 abort  output  1  one-cycle pulse when a granted requester drops req before completion.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 ctr_en  output  1  step strobe to the shared up/down counter; one counter step per cycle high.
REQ-013 ctr_inst  output  1  direction to the counter; valid while ctr_en is high and 0 otherwise.
REQ-014 remaining  output  LEN_W  steps still to issue in the current transaction.

Function
REQ-015 FSM states are IDLE, RUN and DONE; the encoding is free.
REQ-016 IDLE: if any req bit is high at a posedge, the arbiter selects one requester, sets gnt, latches its len into remaining and its dir into a direction register, then enters RUN (len > 0) or DONE (len == 0).
REQ-017 Arbitration is round-robin: if both requesters are high, grant goes to the one not served last. If only one is high, it is granted regardless of the pointer.
REQ-018 The last-served pointer updates at grant time; after reset it points at requester 1, so requester 0 wins the first tie.
REQ-019 RUN: ctr_en = 1 and ctr_inst = latched dir every cycle; remaining decrements by 1 per cycle; on the cycle remaining = 1 the next state is DONE.
REQ-020 A transaction with len = N produces exactly N consecutive ctr_en cycles, starting the cycle after grant, with no gaps.
REQ-021 DONE: ctr_en = 0, done[owner] = 1 for exactly one cycle, gnt is still held, and the next state is IDLE with gnt cleared.
REQ-022 From IDLE, a new grant is issued at the first posedge in IDLE where req is high, so back-to-back transactions have one idle cycle between DONE and the next grant.
REQ-023 req and dir are ignored for the owner after grant, except for the abort check. A change in len or dir mid-transaction has no effect.
REQ-024 Abort: if req[owner] is sampled low in RUN, the FSM goes to IDLE next cycle, abort pulses for one cycle, ctr_en drops that cycle, done is not pulsed, remaining is cleared to 0, and the pointer keeps the aborted owner as last served.
REQ-025 A request from the non-owner during RUN or DONE is held off with no effect until IDLE.
REQ-026 remaining never wraps: it is 0 in IDLE and DONE, and it is never decremented below 1 in RUN.
REQ-027 len = all-ones (255 at default) yields 255 steps with no overflow.

Reset
REQ-028 While reset is low, the block is in IDLE with gnt = 0, done = 0, abort = 0, busy = 0, ctr_en = 0, ctr_inst = 0, remaining = 0, and the pointer at requester 1.
REQ-029 Reset asserted mid-RUN forces ctr_en low asynchronously; the transaction is dropped with no done and no abort pulse.
REQ-030 After reset deasserts, a high req is granted at the first posedge where reset is sampled high.

Verification
REQ-031 Single up: req = 01, dir0 = 0, len0 = 3 -> gnt = 01 next cycle; ctr_en high 3 cycles with ctr_inst = 0; done = 01 for 1 cycle; remaining shows 3, 2, 1.
REQ-032 Tie and round-robin: req = 11 held, len0 = 2, len1 = 2, dir1 = 1 -> requester 0 served first, then requester 1 (ctr_inst = 1), then requester 0 again.
REQ-033 Zero length: req = 10, len1 = 0 -> grant, then DONE the next cycle; done = 10; ctr_en never high.
REQ-034 Abort: req = 01, len0 = 10; drop req0 after 4 ctr_en cycles -> abort pulse, exactly 4 ctr_en cycles total, no done; a pending req1 is granted next.
REQ-035 Async reset: pull reset low mid-RUN between clock edges -> ctr_en, gnt and busy go to 0 without a clock edge; after release, requester 0 wins a tie.
REQ-036 Counter integration: connect to the shared up/down counter, run up 5 then down 2 -> counter value = 3 relative to its start.

Source files
------------

// File: rtl/updown_sched_if.sv
// Request/grant bundle between requesters, the updown_sched arbiter and the
// shared up/down counter it steps.
interface updown_sched_if #(
  parameter int LEN_W = 8
);
  logic [1:0]       req;
  logic [1:0]       dir;
  logic [LEN_W-1:0] len0;
  logic [LEN_W-1:0] len1;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic             abort;
  logic             busy;
  logic             ctr_en;
  logic             ctr_inst;
  logic [LEN_W-1:0] remaining;

  modport master (
    output req, dir, len0, len1,
    input  gnt, done, abort, busy, ctr_en, ctr_inst, remaining
  );

  modport slave (
    input  req, dir, len0, len1,
    output gnt, done, abort, busy, ctr_en, ctr_inst, remaining
  );
endinterface

// File: rtl/updown_sched.sv
// Two-requester round-robin scheduler that drives a shared up/down counter
// for len steps per grant, with abort on early request drop.
module updown_sched #(
  parameter int LEN_W = 8
) (
  input logic           clock,
  input logic           reset,
  updown_sched_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic             last;
  logic             owner;
  logic [1:0]       gnt_q;
  logic [1:0]       done_q;
  logic             abort_q;
  logic             busy_q;
  logic             en_q;
  logic             inst_q;
  logic [LEN_W-1:0] rem_q;

  logic             sel;
  logic [LEN_W-1:0] len_sel;

  // Tie goes to the requester not served last; a lone request wins outright.
  always_comb begin
    sel     = 1'b0;
    len_sel = '0;
    if (bus.req == 2'b11) sel = ~last;
    else                  sel = bus.req[1];
    len_sel = sel ? bus.len1 : bus.len0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      last    <= 1'b1;
      owner   <= 1'b0;
      gnt_q   <= '0;
      done_q  <= '0;
      abort_q <= 1'b0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      inst_q  <= 1'b0;
      rem_q   <= '0;
    end else begin
      done_q  <= '0;
      abort_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|bus.req) begin
            owner  <= sel;
            last   <= sel;
            gnt_q  <= sel ? 2'b10 : 2'b01;
            busy_q <= 1'b1;
            if (len_sel != '0) begin
              state  <= S_RUN;
              rem_q  <= len_sel;
              en_q   <= 1'b1;
              inst_q <= bus.dir[sel];
            end else begin
              state  <= S_DONE;
              rem_q  <= '0;
              done_q <= sel ? 2'b10 : 2'b01;
            end
          end
        end
        S_RUN: begin
          if (!bus.req[owner]) begin
            state   <= S_IDLE;
            abort_q <= 1'b1;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
            inst_q  <= 1'b0;
            rem_q   <= '0;
          end else if (rem_q == LEN_W'(1)) begin
            state  <= S_DONE;
            done_q <= gnt_q;
            en_q   <= 1'b0;
            inst_q <= 1'b0;
            rem_q  <= '0;
          end else begin
            rem_q <= rem_q - LEN_W'(1);
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          gnt_q  <= '0;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          gnt_q  <= '0;
          busy_q <= 1'b0;
          en_q   <= 1'b0;
          inst_q <= 1'b0;
          rem_q  <= '0;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.abort     = abort_q;
  assign bus.busy      = busy_q;
  assign bus.ctr_en    = en_q;
  assign bus.ctr_inst  = inst_q;
  assign bus.remaining = rem_q;

endmodule

// File: tb/tb_updown_sched.sv
// Directed bench for updown_sched: arbitration, step timing, zero length,
// abort, asynchronous reset and net movement of an attached up/down counter.
module tb_updown_sched;

  logic clock;
  logic reset;
  int   total;
  int   passed;
  int   cnt;
  int   base;

  updown_sched_if #(.LEN_W(8)) bus ();

  updown_sched #(.LEN_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Shared up/down counter: inst 0 counts up, 1 counts down.
  always @(posedge clock or negedge reset) begin
    if (!reset)          cnt <= 0;
    else if (bus.ctr_en) cnt <= bus.ctr_inst ? cnt - 1 : cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [1:0] g, input logic [1:0] d,
                            input logic a, input logic b, input logic e, input logic i,
                            input logic [7:0] r);
    chk({tag, ".gnt"},  {30'b0, bus.gnt},       {30'b0, g});
    chk({tag, ".done"}, {30'b0, bus.done},      {30'b0, d});
    chk({tag, ".abort"},{31'b0, bus.abort},     {31'b0, a});
    chk({tag, ".busy"}, {31'b0, bus.busy},      {31'b0, b});
    chk({tag, ".en"},   {31'b0, bus.ctr_en},    {31'b0, e});
    chk({tag, ".inst"}, {31'b0, bus.ctr_inst},  {31'b0, i});
    chk({tag, ".rem"},  {24'b0, bus.remaining}, {24'b0, r});
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (bus.done == 2'b00 && n < 40);
    chk(tag, {31'b0, |bus.done}, 32'd1);
  endtask

  initial begin
    total    = 0;
    passed   = 0;
    reset    = 1'b0;
    bus.req  = 2'b00;
    bus.dir  = 2'b00;
    bus.len0 = 8'd0;
    bus.len1 = 8'd0;

    step();
    expect_out("reset", 2'b00, 2'b00, 0, 0, 0, 0, 8'd0);

    // Tie with fresh pointer: 0, then 1 (counting down), then 0 again.
    reset    = 1'b1;
    bus.req  = 2'b11;
    bus.len0 = 8'd2;
    bus.len1 = 8'd2;
    bus.dir  = 2'b10;
    step(); expect_out("rr0.g",  2'b01, 2'b00, 0, 1, 1, 0, 8'd2);
    step(); expect_out("rr0.r",  2'b01, 2'b00, 0, 1, 1, 0, 8'd1);
    step(); expect_out("rr0.d",  2'b01, 2'b01, 0, 1, 0, 0, 8'd0);
    step(); expect_out("rr0.i",  2'b00, 2'b00, 0, 0, 0, 0, 8'd0);
    step(); expect_out("rr1.g",  2'b10, 2'b00, 0, 1, 1, 1, 8'd2);
    step(); expect_out("rr1.r",  2'b10, 2'b00, 0, 1, 1, 1, 8'd1);
    step(); expect_out("rr1.d",  2'b10, 2'b10, 0, 1, 0, 0, 8'd0);
    step(); expect_out("rr1.i",  2'b00, 2'b00, 0, 0, 0, 0, 8'd0);
    step(); expect_out("rr2.g",  2'b01, 2'b00, 0, 1, 1, 0, 8'd2);
    step(); expect_out("rr2.r",  2'b01, 2'b00, 0, 1, 1, 0, 8'd1);
    step(); expect_out("rr2.d",  2'b01, 2'b01, 0, 1, 0, 0, 8'd0);
    bus.req = 2'b00;
    step(); expect_out("rr2.i",  2'b00, 2'b00, 0, 0, 0, 0, 8'd0);

    // Single up transaction of length 3.
    bus.req  = 2'b01;
    bus.dir  = 2'b00;
    bus.len0 = 8'd3;
    step(); expect_out("up.3", 2'b01, 2'b00, 0, 1, 1, 0, 8'd3);
    step(); expect_out("up.2", 2'b01, 2'b00, 0, 1, 1, 0, 8'd2);
    step(); expect_out("up.1", 2'b01, 2'b00, 0, 1, 1, 0, 8'd1);
    step(); expect_out("up.d", 2'b01, 2'b01, 0, 1, 0, 0, 8'd0);
    bus.req = 2'b00;
    step(); expect_out("up.i", 2'b00, 2'b00, 0, 0, 0, 0, 8'd0);

    // Zero length goes straight to DONE.
    bus.req  = 2'b10;
    bus.len1 = 8'd0;
    step(); expect_out("z.d", 2'b10, 2'b10, 0, 1, 0, 0, 8'd0);
    bus.req = 2'b00;
    step(); expect_out("z.i", 2'b00, 2'b00, 0, 0, 0, 0, 8'd0);

    // Abort after 4 steps; len/dir changes mid-run are ignored; req1 waits.
    bus.req  = 2'b01;
    bus.len0 = 8'd10;
    bus.len1 = 8'd1;
    bus.dir  = 2'b00;
    step(); expect_out("ab.1", 2'b01, 2'b00, 0, 1, 1, 0, 8'd10);
    bus.req  = 2'b11;
    bus.len0 = 8'd3;
    bus.dir  = 2'b01;
    step(); expect_out("ab.2", 2'b01, 2'b00, 0, 1, 1, 0, 8'd9);
    step(); expect_out("ab.3", 2'b01, 2'b00, 0, 1, 1, 0, 8'd8);
    step(); expect_out("ab.4", 2'b01, 2'b00, 0, 1, 1, 0, 8'd7);
    bus.req = 2'b10;
    bus.dir = 2'b00;
    step(); expect_out("ab.a", 2'b00, 2'b00, 1, 0, 0, 0, 8'd0);
    step(); expect_out("ab.g", 2'b10, 2'b00, 0, 1, 1, 0, 8'd1);
    step(); expect_out("ab.d", 2'b10, 2'b10, 0, 1, 0, 0, 8'd0);
    bus.req = 2'b00;
    step(); expect_out("ab.i", 2'b00, 2'b00, 0, 0, 0, 0, 8'd0);

    // Asynchronous reset between edges, then pointer back at requester 1.
    bus.req  = 2'b01;
    bus.len0 = 8'd5;
    step(); expect_out("ar.g", 2'b01, 2'b00, 0, 1, 1, 0, 8'd5);
    step(); expect_out("ar.r", 2'b01, 2'b00, 0, 1, 1, 0, 8'd4);
    #3;
    reset = 1'b0;
    #1;
    expect_out("ar.async", 2'b00, 2'b00, 0, 0, 0, 0, 8'd0);
    step(); expect_out("ar.hold", 2'b00, 2'b00, 0, 0, 0, 0, 8'd0);
    reset    = 1'b1;
    bus.req  = 2'b11;
    bus.len0 = 8'd2;
    bus.len1 = 8'd2;
    step(); expect_out("ar.tie", 2'b01, 2'b00, 0, 1, 1, 0, 8'd2);
    step(); expect_out("ar.r1",  2'b01, 2'b00, 0, 1, 1, 0, 8'd1);
    step(); expect_out("ar.d",   2'b01, 2'b01, 0, 1, 0, 0, 8'd0);
    bus.req = 2'b00;
    step(); expect_out("ar.i",   2'b00, 2'b00, 0, 0, 0, 0, 8'd0);

    // Counter integration: up 5 then down 2.
    base     = cnt;
    bus.req  = 2'b01;
    bus.dir  = 2'b00;
    bus.len0 = 8'd5;
    wait_done("cnt.up.done");
    chk("cnt.up", cnt - base, 32'd5);
    bus.req = 2'b00;
    step();
    bus.req  = 2'b10;
    bus.dir  = 2'b10;
    bus.len1 = 8'd2;
    wait_done("cnt.dn.done");
    chk("cnt.net", cnt - base, 32'd3);
    bus.req = 2'b00;
    step();

    // Full-width length runs to completion without wrapping.
    base     = cnt;
    bus.req  = 2'b01;
    bus.dir  = 2'b00;
    bus.len0 = 8'hFF;
    step(); expect_out("max.g", 2'b01, 2'b00, 0, 1, 1, 0, 8'hFF);
    begin
      int n;
      n = 1;
      while (bus.done == 2'b00 && n < 300) begin
        step();
        n++;
      end
      chk("max.cycles", n, 32'd256);
    end
    chk("max.cnt", cnt - base, 32'd255);
    bus.req = 2'b00;
    step(); expect_out("max.i", 2'b00, 2'b00, 0, 0, 0, 0, 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
